// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared definitions for the clock-enable divider bank: the lock FSM state
// encoding, default widths and the divisor clamp helper.
// -----------------------------------------------------------------------------
package clk_en_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int LOCK_CNT_W_DEF  = 4;
  localparam int DIV_DEFAULT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKWAIT = 2'd1,
    RUN      = 2'd2
  } lock_state_e;

  // A programmed divisor of 0 behaves like 1 (pulse every cycle).
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_en_div_ch.sv
// -----------------------------------------------------------------------------
// clk_en_div_ch
// One clock-enable channel: period counter, shadow divisor, pending flag and
// load acknowledge. A newly loaded divisor only takes effect at a period
// boundary, while idle, or on sync, so a running period is never cut short.
//
// Optional feature (macro CLK_EN_PHASE_EN): counter preloads with a per-channel
// phase offset on RUN entry and on sync.
//
// Ports:
//   clk, rst     fabric clock, synchronous active-high reset
//   in_run       lock FSM is in RUN
//   lock_s       synchronised PLL lock (low in RUN means RUN is being left)
//   ch_en        channel run enable
//   sync         realign counter, apply pending divisor
//   div_load     load div_val into the shadow divisor
//   div_val      requested divisor
//   run_start    (CLK_EN_PHASE_EN) FSM enters RUN this edge
//   ph_val       (CLK_EN_PHASE_EN) requested phase offset
//   div_ack      one-cycle pulse when the shadow divisor becomes active
//   clk_en       registered enable pulse
// -----------------------------------------------------------------------------
module clk_en_div_ch
  import clk_en_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(DIV_DEFAULT_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_run,
  input  logic             lock_s,
  input  logic             ch_en,
  input  logic             sync,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
`ifdef CLK_EN_PHASE_EN
  input  logic             run_start,
  input  logic [DIV_W-1:0] ph_val,
`endif
  output logic             div_ack,
  output logic             clk_en
);

  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] restart_val;
  logic             pend;
  logic             idle;
  logic             counting;
  logic             tc;
  logic             apply;

  assign d        = DIV_W'(clamp_div(32'(active)));
  assign idle     = !in_run || !ch_en;
  // In RUN with lock_s low the FSM is leaving RUN: no count, no pulse, and
  // the pending divisor waits for the following idle cycle.
  assign counting = in_run && lock_s && ch_en && !sync;
  assign tc       = (cnt == d - 1'b1);
  assign apply    = pend && (idle || sync || (counting && tc));

`ifdef CLK_EN_PHASE_EN
  logic [DIV_W-1:0] d_next;
  logic [DIV_W-1:0] ph_lim;
  logic             preload;

  // Clamp the offset against the divisor that will be active next cycle.
  assign d_next      = apply ? DIV_W'(clamp_div(32'(shadow))) : d;
  assign ph_lim      = (ph_val > d_next - 1'b1) ? d_next - 1'b1 : ph_val;
  assign preload     = ch_en && ((sync && in_run && lock_s) || run_start);
  assign restart_val = preload ? ph_lim : '0;
`else
  assign restart_val = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= DIV_DEFAULT;
      shadow  <= DIV_DEFAULT;
      pend    <= 1'b0;
      cnt     <= '0;
      clk_en  <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= apply;
      if (apply) active <= shadow;

      // A load coinciding with an apply leaves the new value pending.
      if (div_load) begin
        shadow <= div_val;
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end

      if (counting) begin
        if (tc) begin
          cnt    <= '0;
          clk_en <= 1'b1;
        end else begin
          cnt    <= cnt + 1'b1;
          clk_en <= 1'b0;
        end
      end else begin
        cnt    <= restart_val;
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_en_divider_bank.sv
// -----------------------------------------------------------------------------
// clk_en_divider_bank
// Produces NUM_CH independent clock-enable pulse trains from the PLL fabric
// clock, each with a runtime-programmable divisor, gated on a debounced PLL
// lock. Holds the lock synchroniser, the lock FSM and the sync fan-out.
//
// Optional feature (macro CLK_EN_PHASE_EN): adds ph_val_i, a per-channel phase
// offset preloaded into the counters on RUN entry and on sync_i.
//
// Ports:
//   clk          fabric clock (PLL OUT0 via CLKINT)
//   rst          synchronous active-high reset
//   pll_lock_i   raw PLL lock, asynchronous to clk
//   ch_en_i      per-channel run enable
//   div_val_i    requested divisors, channel c at [c*DIV_W +: DIV_W]
//   div_load_i   per-channel load strobe into the shadow divisor
//   sync_i       realign all channel counters
//   ph_val_i     (CLK_EN_PHASE_EN) per-channel phase offsets
//   div_ack_o    per-channel pulse when a shadow divisor becomes active
//   clk_en_o     per-channel registered enable pulse
//   locked_o     high while the FSM is in RUN
// -----------------------------------------------------------------------------
module clk_en_divider_bank
  import clk_en_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int LOCK_CNT_W  = LOCK_CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_lock_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_val_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic                    sync_i,
`ifdef CLK_EN_PHASE_EN
  input  logic [NUM_CH*DIV_W-1:0] ph_val_i,
`endif
  output logic [NUM_CH-1:0]       div_ack_o,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic                    locked_o
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = '1;

  logic                  lock_meta;
  logic                  lock_s;
  lock_state_e           state;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  in_run;

  // Two-flop synchroniser; nothing else looks at pll_lock_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  // Lock debounce FSM; locked_o is registered alongside the state so it
  // always equals (state == RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      locked_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_s) begin
            state    <= LOCKWAIT;
            lock_cnt <= '0;
          end
        end
        LOCKWAIT: begin
          if (!lock_s) begin
            state <= IDLE;
          end else if (lock_cnt == LOCK_MAX) begin
            state    <= RUN;
            locked_o <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state    <= IDLE;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  assign in_run = (state == RUN);

`ifdef CLK_EN_PHASE_EN
  logic run_start;
  assign run_start = (state == LOCKWAIT) && lock_s && (lock_cnt == LOCK_MAX);
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_en_div_ch #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_W'(DIV_DEFAULT))
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_run    (in_run),
      .lock_s    (lock_s),
      .ch_en     (ch_en_i[c]),
      .sync      (sync_i),
      .div_load  (div_load_i[c]),
      .div_val   (div_val_i[c*DIV_W +: DIV_W]),
`ifdef CLK_EN_PHASE_EN
      .run_start (run_start),
      .ph_val    (ph_val_i[c*DIV_W +: DIV_W]),
`endif
      .div_ack   (div_ack_o[c]),
      .clk_en    (clk_en_o[c])
    );
  end

endmodule

// File: tb/tb_clk_en_divider_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_en_divider_bank
// Scoreboard bench: the driver applies stimulus on the falling edge, runs an
// event-scheduling reference model and queues the expected outputs for the
// next rising edge; a monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_en_divider_bank;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CNT_W  = 4;
  localparam int DIV_DEFAULT = 8;
  // Consecutive edges with synced lock high that end in RUN (IDLE edge + full count).
  localparam int RUN_STREAK  = (1 << LOCK_CNT_W) + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    pll_lock_i = 1'b0;
  logic [NUM_CH-1:0]       ch_en_i = '0;
  logic [NUM_CH*DIV_W-1:0] div_val_i = '0;
  logic [NUM_CH-1:0]       div_load_i = '0;
  logic                    sync_i = 1'b0;
  logic [NUM_CH-1:0]       div_ack_o;
  logic [NUM_CH-1:0]       clk_en_o;
  logic                    locked_o;

  always #5 clk = ~clk;

  clk_en_divider_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CNT_W  (LOCK_CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock_i (pll_lock_i),
    .ch_en_i    (ch_en_i),
    .div_val_i  (div_val_i),
    .div_load_i (div_load_i),
    .sync_i     (sync_i),
    .div_ack_o  (div_ack_o),
    .clk_en_o   (clk_en_o),
    .locked_o   (locked_o)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] ack;
    logic              locked;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: each channel remembers the absolute edge at which its
  // next pulse is due; lock is tracked as a run of consecutive synced-high edges.
  int m_active[NUM_CH];
  int m_shadow[NUM_CH];
  int m_due[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_run;
  int streak;
  bit hist[2];
  int edge_n = 0;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge(input bit r, input bit pl, input logic [NUM_CH-1:0] en,
                            input logic [NUM_CH-1:0] ld,
                            input logic [NUM_CH*DIV_W-1:0] vals, input bit s);
    exp_t x;
    bit   ls;
    x = '0;
    edge_n++;
    if (r) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_active[c] = DIV_DEFAULT;
        m_shadow[c] = DIV_DEFAULT;
        m_pend[c]   = 1'b0;
        m_due[c]    = 0;
      end
      m_run   = 1'b0;
      streak  = 0;
      hist[0] = 1'b0;
      hist[1] = 1'b0;
      sb.push_back(x);
      return;
    end
    ls = hist[0];
    for (int c = 0; c < NUM_CH; c++) begin
      bit idle, counting, tc, apply;
      idle     = !m_run || !en[c];
      counting = m_run && ls && en[c] && !s;
      tc       = counting && (edge_n == m_due[c]);
      apply    = m_pend[c] && (idle || s || tc);
      x.en[c]  = tc;
      x.ack[c] = apply;
      if (apply) m_active[c] = m_shadow[c];
      if (ld[c]) begin
        m_shadow[c] = int'(vals[c*DIV_W +: DIV_W]);
        m_pend[c]   = 1'b1;
      end else if (apply) begin
        m_pend[c] = 1'b0;
      end
      if (!counting || tc) m_due[c] = edge_n + eff(m_active[c]);
    end
    streak   = ls ? streak + 1 : 0;
    if (streak > 1000) streak = 1000;
    m_run    = (streak >= RUN_STREAK);
    x.locked = m_run;
    hist[0]  = hist[1];
    hist[1]  = pl;
    sb.push_back(x);
  endtask

  // Driver state.
  bit                cur_lock = 1'b0;
  logic [NUM_CH-1:0] cur_en   = '1;

  task automatic cyc(input bit r, input logic [NUM_CH-1:0] ld,
                     input logic [NUM_CH*DIV_W-1:0] vals, input bit s);
    @(negedge clk);
    rst        = r;
    pll_lock_i = cur_lock;
    ch_en_i    = cur_en;
    div_load_i = ld;
    div_val_i  = vals;
    sync_i     = s;
    model_edge(r, cur_lock, cur_en, ld, vals, s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0);
  endtask

  task automatic load_one(input int c, input int v);
    logic [NUM_CH-1:0]       ld;
    logic [NUM_CH*DIV_W-1:0] vals;
    ld            = '0;
    vals          = '0;
    ld[c]         = 1'b1;
    vals[c*DIV_W +: DIV_W] = DIV_W'(v);
    cyc(1'b0, ld, vals, 1'b0);
  endtask

  // Monitor: compares every DUT output vector against the queued expectation.
  initial begin
    forever begin
      exp_t want, got;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        want = sb.pop_front();
        got  = {clk_en_o, div_ack_o, locked_o};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs @%0t: got clk_en=%b ack=%b locked=%b, expected clk_en=%b ack=%b locked=%b",
                   $time, got.en, got.ack, got.locked, want.en, want.ack, want.locked);
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0]       ld;
    logic [NUM_CH*DIV_W-1:0] vals;

    // Reset, lock absent, then steady lock: RUN and default period 8.
    repeat (3) cyc(1'b1, '0, '0, 1'b0);
    run(5);
    cur_lock = 1'b1;
    run(40);

    // Lock drop in RUN, then a one-cycle glitch during LOCKWAIT.
    cur_lock = 1'b0; run(1);
    cur_lock = 1'b1; run(8);
    cur_lock = 1'b0; run(1);
    cur_lock = 1'b1; run(30);

    // Mid-period load on ch1.
    run(2);
    load_one(1, 3);
    run(20);

    // Divisors 0 and 1, then back-to-back loads 0 and 5 on ch0.
    ld = 4'b1100;
    vals = '0;
    vals[2*DIV_W +: DIV_W] = 8'd0;
    vals[3*DIV_W +: DIV_W] = 8'd1;
    cyc(1'b0, ld, vals, 1'b0);
    run(10);
    load_one(0, 0);
    load_one(0, 5);
    run(20);

    // Divisors 4 and 6, then sync realignment.
    ld = 4'b0011;
    vals = '0;
    vals[0 +: DIV_W]     = 8'd4;
    vals[DIV_W +: DIV_W] = 8'd6;
    cyc(1'b0, ld, vals, 1'b0);
    run(15);
    cyc(1'b0, '0, '0, 1'b1);
    run(30);

    // Lock lost with a load pending, then relock.
    run(1);
    load_one(1, 2);
    cur_lock = 1'b0; run(6);
    cur_lock = 1'b1; run(30);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      bit r, s;
      r = ($urandom_range(1499) == 0);
      if ($urandom_range(199) == 0) cur_lock = 1'b0;
      else if (!cur_lock && $urandom_range(2) == 0) cur_lock = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(49) == 0) cur_en[c] = ~cur_en[c];
        ld[c] = ($urandom_range(11) == 0);
        vals[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(12));
      end
      s = ($urandom_range(59) == 0);
      cyc(r, ld, vals, s);
    end

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d undrained entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
